// File: rtl/adc_preview_reader.sv
// Sweeps the ADC preview buffer once per start request. Read data is realigned through a latency tag pipe,
// optionally decimated, and streamed out of a small skid FIFO as a valid/ready byte stream.
module adc_preview_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 512,
  parameter int RD_LAT     = 2,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              peak_mode,
  input  logic              data_ready,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              sample_last,
  output logic              busy,
  output logic              done
);
  localparam int NGRP = DEPTH / DECIM;
  localparam int GW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int NW   = $clog2(NGRP + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(2 * FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_peak;
  logic [RD_LAT-1:0]   r_tag;
  logic [GW-1:0]       r_grp;
  logic [DATA_W-1:0]   r_acc;
  logic [NW-1:0]       r_gidx;
  logic [SW-1:0]       r_owed;
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;

  logic                w_start_acc, w_first, w_credit, w_issue, w_cap, w_grp_end;
  logic                w_push, w_pop, w_last;
  logic [DATA_W-1:0]   w_val;

  assign bram_addr   = r_addr;
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_first     = (DECIM == 1) || (r_addr[GW-1:0] == '0);
  // Credit is taken once per group when its first address issues; r_owed covers in-flight and partial groups.
  assign w_credit    = (r_owed + SW'(r_count)) < SW'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_SCAN) && (!w_first || w_credit);
  assign w_cap       = r_tag[RD_LAT-1];
  assign w_grp_end   = w_cap && (r_grp == GW'(DECIM - 1));
  assign w_push      = w_grp_end;
  assign w_pop       = sample_valid && sample_ready;
  assign w_last      = (r_gidx == NW'(NGRP - 1));

  always_comb begin
    w_val = r_acc;
    if (r_grp == '0 || (r_peak && bram_dout > r_acc))
      w_val = bram_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start)      w_next = S_WAIT_RDY;
      S_WAIT_RDY: if (data_ready) w_next = S_SCAN;
      S_SCAN:     if (w_issue && r_addr == ADDR_W'(DEPTH - 1)) w_next = S_DRAIN;
      S_DRAIN:    if (r_owed == '0 && (r_count == '0 || (r_count == CW'(1) && w_pop)))
                    w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_WAIT_RDY, S_SCAN, S_DRAIN: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default:                     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_peak <= 1'b0;
      r_tag  <= '0;
      r_grp  <= '0;
      r_acc  <= '0;
      r_gidx <= '0;
      r_owed <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int unsigned i = 1; i < RD_LAT; i++)
        r_tag[i] <= r_tag[i-1];
      r_owed <= r_owed + SW'(w_issue && w_first) - SW'(w_push);
      if (w_start_acc) begin
        r_addr <= '0;
        r_peak <= peak_mode;
        r_grp  <= '0;
        r_acc  <= '0;
        r_gidx <= '0;
      end else begin
        if (w_issue && r_addr != ADDR_W'(DEPTH - 1))
          r_addr <= r_addr + ADDR_W'(1);
        if (w_cap) begin
          r_grp <= w_grp_end ? '0 : r_grp + GW'(1);
          r_acc <= w_grp_end ? '0 : w_val;
        end
        if (w_push)
          r_gidx <= r_gidx + NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {w_last, w_val};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Head is gated so stale entries left by an aborted sweep never reach the outputs.
  assign sample_valid = (r_count != '0);
  assign sample_data  = sample_valid ? r_mem[r_rptr][DATA_W-1:0] : '0;
  assign sample_last  = sample_valid & r_mem[r_rptr][DATA_W];

endmodule

// File: tb/tb_adc_preview_reader.sv
// Bench for adc_preview_reader: a DECIM=1 and a DECIM=4 instance, each fed by a 2-cycle-latency memory
// model, with frames checked against group-first/group-max expectations computed from the memory image.
module tb_adc_preview_reader;
  localparam int DEPTH = 512;
  localparam int FD    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      start, peak, drdy, s_valid, s_ready, s_last, busy, done;
  logic [1:0][8:0] b_addr;
  logic [1:0][7:0] b_dout, s_data;
  logic [8:0]      ra [2];
  logic [7:0]      mem [2][DEPTH];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int ovf_cnt = 0;

  adc_preview_reader #(.ADDR_W(9), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(2), .DECIM(1), .FIFO_DEPTH(FD)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .peak_mode(peak[0]), .data_ready(drdy[0]),
    .bram_addr(b_addr[0]), .bram_dout(b_dout[0]), .sample_data(s_data[0]), .sample_valid(s_valid[0]),
    .sample_ready(s_ready[0]), .sample_last(s_last[0]), .busy(busy[0]), .done(done[0]));

  adc_preview_reader #(.ADDR_W(9), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(2), .DECIM(4), .FIFO_DEPTH(FD)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .peak_mode(peak[1]), .data_ready(drdy[1]),
    .bram_addr(b_addr[1]), .bram_dout(b_dout[1]), .sample_data(s_data[1]), .sample_valid(s_valid[1]),
    .sample_ready(s_ready[1]), .sample_last(s_last[1]), .busy(busy[1]), .done(done[1]));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      ra[u]     <= b_addr[u];
      b_dout[u] <= mem[u][ra[u]];
    end
  end

  always @(negedge clk) begin
    if ((dut0.w_push && dut0.r_count == FD) || (dut4.w_push && dut4.r_count == FD)) ovf_cnt++;
    a_no_ovf: assert (!((dut0.w_push && dut0.r_count == FD) || (dut4.w_push && dut4.r_count == FD)))
      else $error("skid fifo written while full");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic next_ready(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return ($urandom_range(0, 3) == 0);
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic run_frame(input int u, input bit pk, input int rmode, input int dr_wait,
                           input int restart_at, input int abort_at, input string nm);
    int decim, n_exp, S, R, nb, first_v, last_cyc, ndone, done_c, bfirst, blast, bcnt;
    int derr, lerr, gap_err, stall_err, addr_err, extra, fmax, cnt, stl;
    bit pend, restarted, aborted;
    logic plast;
    logic [7:0] pdata;
    logic [7:0] exp_d [DEPTH];
    decim = (u == 0) ? 1 : 4;
    n_exp = DEPTH / decim;
    for (int k = 0; k < n_exp; k++) begin
      exp_d[k] = mem[u][k*decim];
      if (pk)
        for (int j = 1; j < decim; j++)
          if (mem[u][k*decim+j] > exp_d[k]) exp_d[k] = mem[u][k*decim+j];
    end
    {nb, ndone, done_c, bcnt, derr, lerr, gap_err, stall_err, addr_err, extra, fmax, stl} = '0;
    first_v = -1; bfirst = -1; blast = -1; last_cyc = -1;
    pend = 0; restarted = 0; aborted = 0; plast = 0; pdata = '0;

    @(posedge clk); #1;
    S = cyc;
    start[u] = 1'b1; peak[u] = pk; drdy[u] = (dr_wait == 0); s_ready[u] = next_ready(rmode);
    R = (dr_wait == 0) ? S + 1 : S + dr_wait + 1;
    for (int t = 0; t < 20000 && ndone == 0 && !aborted; t++) begin
      @(negedge clk);
      if (busy[u]) begin
        if (bfirst < 0) bfirst = cyc;
        blast = cyc; bcnt++;
      end
      if (done[u]) begin ndone++; done_c = cyc; end
      if (pend && !(s_valid[u] && s_data[u] == pdata && s_last[u] == plast)) stall_err++;
      if (s_valid[u] && first_v < 0) first_v = cyc;
      if (s_valid[u] && s_ready[u]) begin
        if (nb < n_exp) begin
          if (s_data[u] != exp_d[nb]) derr++;
          if (s_last[u] != (nb == n_exp - 1)) lerr++;
          if (nb > 0 && cyc != last_cyc + 1) gap_err++;
        end else extra++;
        last_cyc = cyc; nb++;
      end
      pend = s_valid[u] && !s_ready[u]; pdata = s_data[u]; plast = s_last[u];
      if (cyc > S && cyc <= R + 1 && b_addr[u] != 0) addr_err++;
      cnt = (u == 0) ? int'(dut0.r_count) : int'(dut4.r_count);
      if (cnt > fmax) fmax = cnt;
      @(posedge clk); #1;
      start[u] = 1'b0;
      if (restart_at >= 0 && !restarted && nb == restart_at) begin start[u] = 1'b1; restarted = 1; end
      if (cyc >= S + dr_wait + 1) drdy[u] = 1'b1;
      s_ready[u] = next_ready(rmode);
      if (abort_at >= 0 && nb >= abort_at) begin
        s_ready[u] = 1'b0; stl++;
        if (stl == 4) begin
          #2;
          check_eq({nm, "_stalled_valid"}, s_valid[u], 1);
          reset_n = 1'b0; #1;
          check_eq({nm, "_rst_valid"}, s_valid[u], 0);
          check_eq({nm, "_rst_data"}, s_data[u], 0);
          check_eq({nm, "_rst_last"}, s_last[u], 0);
          check_eq({nm, "_rst_busy"}, busy[u], 0);
          check_eq({nm, "_rst_done"}, done[u], 0);
          check_eq({nm, "_rst_addr"}, b_addr[u], 0);
          aborted = 1;
        end
      end
    end
    check_eq({nm, "_data_err"}, derr, 0);
    check_eq({nm, "_last_err"}, lerr, 0);
    check_eq({nm, "_stall_err"}, stall_err, 0);
    check_eq({nm, "_wait_addr_err"}, addr_err, 0);
    check_eq({nm, "_fifo_max_ok"}, int'(fmax <= FD), 1);
    check_eq({nm, "_overflow"}, ovf_cnt, 0);
    if (aborted) begin
      check_eq({nm, "_beats_at_abort"}, nb, abort_at);
      check_eq({nm, "_done_cnt"}, ndone, 0);
    end else begin
      check_eq({nm, "_beats"}, nb, n_exp);
      check_eq({nm, "_extra"}, extra, 0);
      check_eq({nm, "_done_cnt"}, ndone, 1);
      check_eq({nm, "_done_cyc"}, done_c, last_cyc + 1);
      check_eq({nm, "_busy_first"}, bfirst, S + 1);
      check_eq({nm, "_busy_last"}, blast, done_c - 1);
      check_eq({nm, "_busy_cnt"}, bcnt, done_c - S - 1);
      check_eq({nm, "_first_valid"}, first_v, R + 3 + decim);
      if (decim == 1 && rmode == 0) check_eq({nm, "_gaps"}, gap_err, 0);
    end
  endtask

  initial begin
    int bad;
    start = '0; peak = '0; drdy = '0; s_ready = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem[0][k] = 8'(k);
      case (k % 4)
        0: mem[1][k] = 8'd3;
        1, 2: mem[1][k] = 8'd9;
        default: mem[1][k] = 8'd1;
      endcase
    end
    repeat (3) @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("rst%0d_valid", u), s_valid[u], 0);
      check_eq($sformatf("rst%0d_data", u), s_data[u], 0);
      check_eq($sformatf("rst%0d_last", u), s_last[u], 0);
      check_eq($sformatf("rst%0d_busy", u), busy[u], 0);
      check_eq($sformatf("rst%0d_done", u), done[u], 0);
      check_eq($sformatf("rst%0d_addr", u), b_addr[u], 0);
    end
    reset_n = 1'b1;

    run_frame(0, 0, 0, 0, -1, -1, "t1_base");
    run_frame(0, 0, 0, 20, -1, -1, "t2_drwait");
    run_frame(0, 0, 1, 0, -1, -1, "t3_stall");
    run_frame(1, 1, 0, 0, -1, -1, "t4_peak");
    run_frame(1, 0, 0, 0, -1, -1, "t4_first");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) mem[1][k] = 8'($urandom_range(0, 255));
      run_frame(1, 1'($urandom_range(0, 1)), 2, $urandom_range(0, 5), -1, -1, $sformatf("t5_rand4_%0d", r));
    end
    for (int k = 0; k < DEPTH; k++) mem[0][k] = 8'($urandom_range(0, 255));
    run_frame(0, 0, 2, $urandom_range(0, 5), -1, -1, "t5_rand1");
    for (int k = 0; k < DEPTH; k++) mem[0][k] = 8'(k);

    run_frame(0, 0, 0, 0, -1, 100, "t6_abort");
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (done[0] || s_valid[0] || busy[0]) bad++;
    end
    check_eq("t6_quiet_after_abort", bad, 0);
    run_frame(0, 0, 0, 0, -1, -1, "t6_after");
    run_frame(0, 0, 0, 0, 50, -1, "t7_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_preview_reader.md
Name: adc_preview_reader

Overview:
- Consumer stage directly downstream of the ADC preview sample buffer (512 x 8 registered-output ROM/BRAM).
- On a start request, sweeps the buffer address range once and compensates for the buffer's fixed read latency.
- Optionally decimates by DECIM, in first-sample or peak-hold mode.
- Delivers the result as a valid/ready byte stream with end-of-frame marking, for the host/display path.

Parameters:
- ADDR_W, 9, buffer address width.
- DATA_W, 8, sample width.
- DEPTH, 512, samples per sweep; must be a multiple of DECIM and ≤ 2^ADDR_W.
- RD_LAT, 2, cycles from bram_addr change to matching bram_dout (address register + output register).
- DECIM, 1, input samples per output beat; allowed values 1, 2, 4, 8.
- FIFO_DEPTH, 4, output skid FIFO entries; must be ≥ RD_LAT+1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- peak_mode  in  1  0: output the first sample of each group; 1: output the group maximum. Sampled when start is accepted.
- data_ready  in  1  buffer contents valid; sweep addressing waits for it.
- bram_addr  out  ADDR_W  read address to the sample buffer.
- bram_dout  in  DATA_W  read data from the sample buffer, RD_LAT cycles after bram_addr.
- sample_data  out  DATA_W  output beat data.
- sample_valid  out  1  output beat valid.
- sample_ready  in  1  downstream accepts a beat when valid&ready.
- sample_last  out  1  marks the final beat of the sweep, index DEPTH/DECIM-1.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, bram_addr=0, sample_valid=0, sample_last=0, sample_data=0, busy=0, done=0, FIFO empty, in-flight counter=0, decimation accumulator=0.
- States:
  - IDLE: on start, latch peak_mode, set busy=1, go to WAIT_RDY.
  - WAIT_RDY: when data_ready=1, go to SCAN. No address is issued here.
  - SCAN: one address per cycle while credit is available.
    - Credit rule: fifo_count + inflight_groups + (accumulator holding a partial group ? 1 : 0) < FIFO_DEPTH, evaluated per completed-group boundary.
    - With no credit, bram_addr holds and no read is counted.
    - After issuing address DEPTH-1, go to DRAIN.
  - DRAIN: no new addresses. Wait until all in-flight reads have landed and the FIFO is empty with the final beat accepted, then go to DONE.
  - DONE: done=1 and busy→0 for one cycle, then IDLE.
- Read tracking: a RD_LAT-deep valid shift register tags each issued address. Captured bram_dout is qualified by the tag exiting the shift register. Stalled (non-issued) cycles insert 0 tags.
- Decimation: the group counter runs 0..DECIM-1 over captured samples.
  - peak_mode=0 keeps sample 0 of the group.
  - peak_mode=1 keeps the unsigned max, with ties keeping the earlier value.
  - On group completion, write one FIFO entry {data, last}; last=1 for group DEPTH/DECIM-1.
- Output: sample_valid = FIFO non-empty; sample_data/sample_last come from the FIFO head. Data holds stable while valid & !ready. Back-to-back beats occur at 1/cycle when ready is held high.
- Latency, DECIM=1, ready=1: first address is issued the cycle after SCAN is entered. Beat 0 has sample_valid=1 RD_LAT+1 cycles after address 0 is issued. The sweep emits DEPTH beats on consecutive cycles with no bubbles.
- FIFO full: the credit rule guarantees FIFO overflow never occurs. A write while full is a design error and must be flagged by a bench assertion.
- Simultaneous FIFO push and pop when full or empty: both take effect and the count is unchanged.
- Address wrap: bram_addr never exceeds DEPTH-1 and resets to 0 at the start of each sweep. There is no address wrap-around within a sweep.
- data_ready deasserting during SCAN does not pause the sweep.
- start while busy: ignored, with no restart.
- Reset mid-sweep: immediate abort to IDLE. The FIFO is flushed, no done pulse is produced, and the partial frame is discarded.

Test Plan:
- Memory model returns bram_dout = addr[7:0] with RD_LAT=2, DECIM=1, ready=1; pulse start → 512 beats with values 0..255,0..255 on consecutive cycles, sample_last only on beat 511, done one cycle after beat 511, busy spans start+1..done.
- Same setup with data_ready held 0 for 20 cycles after start → bram_addr stays 0, no reads during the wait; sweep starts the cycle after data_ready rises.
- sample_ready toggled 1-cycle-on/3-off randomly → beat sequence and data are identical to the first test, no dropped or duplicated beats, FIFO count never exceeds 4, data stable while stalled.
- DECIM=4, peak_mode=1, memory returns {3,9,9,1} repeating → 128 beats of value 9, last on beat 127. With peak_mode=0 → 128 beats of value 3.
- Assert reset_n low while beat 100 is stalled → all outputs return to reset values asynchronously, no done pulse. A fresh start afterwards produces a full correct 512-beat frame.
- start pulsed again at beat 50 of an active sweep → no restart, frame completes normally with exactly 512 beats and one done pulse.
